bp_be_stride_prefetch_gen: RTL and testbench

//  Consumer end of the loop-inference descriptor interface: accepts {pc, eff_addr, stride,

---
 rtl/bp_be_stride_prefetch_gen.sv | 123 ++++++++++++
 tb/tb_bp_be_stride_prefetch_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_stride_prefetch_gen.sv
// Stride prefetch generator: turns a loop-inference descriptor into a walk of strided
// addresses and issues one line-aligned prefetch per new cache line to the dcache.
module bp_be_stride_prefetch_gen
    #(parameter int vaddr_width_p          = 39
    , parameter int output_range_p         = 8
    , parameter int effective_addr_width_p = vaddr_width_p
    , parameter int stride_width_p         = 8
    , parameter int max_prefetch_p         = 16
    , parameter int block_offset_width_p   = 6
    )
    ( input  logic                              clk_i
    , input  logic                              reset_i

    , input  logic                              v_i
    , output logic                              yumi_o
    , input  logic [vaddr_width_p-1:0]          pc_i
    , input  logic [effective_addr_width_p-1:0] eff_addr_i
    , input  logic [stride_width_p-1:0]         stride_i
    , input  logic [output_range_p-1:0]         remaining_iterations_i
    , input  logic                              flush_i

    , output logic                              pf_v_o
    , output logic [effective_addr_width_p-1:0] pf_vaddr_o
    , input  logic                              pf_ready_and_i
    , output logic [vaddr_width_p-1:0]          pf_pc_o
    , output logic                              busy_o
    );

    localparam int cnt_width_lp  = $clog2(max_prefetch_p + 1);
    localparam int line_width_lp = effective_addr_width_p - block_offset_width_p;

    typedef enum logic [1:0] {e_idle, e_calc, e_issue} state_e;

    state_e                              state_r, state_n;
    logic [vaddr_width_p-1:0]            pc_r, pc_n;
    logic [effective_addr_width_p-1:0]   addr_r, addr_n;
    logic [effective_addr_width_p-1:0]   stride_r, stride_n;
    logic [line_width_lp-1:0]            last_line_r, last_line_n;
    logic [cnt_width_lp-1:0]             cnt_r, cnt_n;

    logic [effective_addr_width_p-1:0]   stride_sext;
    logic [line_width_lp-1:0]            addr_line;
    logic                                dup_line;

    assign stride_sext = {{(effective_addr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign addr_line   = addr_r[effective_addr_width_p-1:block_offset_width_p];
    assign dup_line    = (addr_line == last_line_r);

    assign pf_vaddr_o  = {addr_line, {block_offset_width_p{1'b0}}};
    assign pf_pc_o     = pc_r;
    assign busy_o      = (state_r != e_idle);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state_r;
        pc_n        = pc_r;
        addr_n      = addr_r;
        stride_n    = stride_r;
        last_line_n = last_line_r;
        cnt_n       = cnt_r;
        yumi_o      = 1'b0;
        pf_v_o      = 1'b0;

        // Flush wins over everything: no handshake on either side completes this cycle.
        if (flush_i) begin
            state_n = e_idle;
            cnt_n   = '0;
        end else begin
            unique case (state_r)
                e_idle: begin
                    yumi_o = v_i;
                    if (v_i) begin
                        pc_n        = pc_i;
                        addr_n      = eff_addr_i + stride_sext;
                        stride_n    = stride_sext;
                        last_line_n = eff_addr_i[effective_addr_width_p-1:block_offset_width_p];
                        if (32'(remaining_iterations_i) > max_prefetch_p)
                            cnt_n = cnt_width_lp'(max_prefetch_p);
                        else
                            cnt_n = cnt_width_lp'(remaining_iterations_i);
                        state_n = e_calc;
                    end
                end
                e_calc: begin
                    state_n = ((cnt_r == '0) || (stride_r == '0)) ? e_idle : e_issue;
                end
                e_issue: begin
                    // Candidates in the last requested line are skipped without a request.
                    pf_v_o = ~dup_line;
                    if (dup_line || pf_ready_and_i) begin
                        addr_n = addr_r + stride_r;
                        cnt_n  = cnt_r - cnt_width_lp'(1);
                        if (!dup_line)
                            last_line_n = addr_line;
                        if (cnt_r == cnt_width_lp'(1))
                            state_n = e_idle;
                    end
                end
                default: state_n = e_idle;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            pc_r        <= '0;
            addr_r      <= '0;
            stride_r    <= '0;
            last_line_r <= '0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_n;
            pc_r        <= pc_n;
            addr_r      <= addr_n;
            stride_r    <= stride_n;
            last_line_r <= last_line_n;
            cnt_r       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Directed bench for bp_be_stride_prefetch_gen: hand-computed request sequences,
// latency, backpressure, flush, reset and address wrap.
module tb_bp_be_stride_prefetch_gen;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        yumi_o;
    logic [38:0] pc_i;
    logic [38:0] eff_addr_i;
    logic [7:0]  stride_i;
    logic [7:0]  remaining_iterations_i;
    logic        flush_i;
    logic        pf_v_o;
    logic [38:0] pf_vaddr_o;
    logic        pf_ready_and_i;
    logic [38:0] pf_pc_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [38:0] got_q[$];
    int          got_idx[$];
    logic [38:0] exp_q[$];
    int          end_idx;

    bp_be_stride_prefetch_gen dut
        ( .clk_i                  (clk_i)
        , .reset_i                (reset_i)
        , .v_i                    (v_i)
        , .yumi_o                 (yumi_o)
        , .pc_i                   (pc_i)
        , .eff_addr_i             (eff_addr_i)
        , .stride_i               (stride_i)
        , .remaining_iterations_i (remaining_iterations_i)
        , .flush_i                (flush_i)
        , .pf_v_o                 (pf_v_o)
        , .pf_vaddr_o             (pf_vaddr_o)
        , .pf_ready_and_i         (pf_ready_and_i)
        , .pf_pc_o                (pf_pc_o)
        , .busy_o                 (busy_o)
        );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a descriptor in IDLE; returns at posedge+1 of the cycle after yumi.
    task automatic send(input logic [38:0] pc, input logic [38:0] addr,
                        input logic [7:0] stride, input logic [7:0] rem);
        pc_i = pc; eff_addr_i = addr; stride_i = stride; remaining_iterations_i = rem; v_i = 1'b1;
        #1 check("yumi", {63'd0, yumi_o}, 64'd1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
    endtask

    // Record accepted requests per cycle until busy drops, within a cycle budget.
    task automatic collect(input int budget);
        end_idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                end_idx = i;
                break;
            end
            if (pf_v_o && pf_ready_and_i) begin
                got_q.push_back(pf_vaddr_o);
                got_idx.push_back(i);
            end
        end
        check("collect_done", {63'd0, (end_idx >= 0)}, 64'd1);
    endtask

    task automatic clear();
        got_q.delete();
        got_idx.delete();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < got_q.size())
                check(tag, {25'd0, got_q[k]}, {25'd0, exp_q[k]});
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; flush_i = 1'b0; pf_ready_and_i = 1'b1;
        pc_i = '0; eff_addr_i = '0; stride_i = '0; remaining_iterations_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy",   {63'd0, busy_o}, 64'd0);
        check("rst_pf_v",   {63'd0, pf_v_o}, 64'd0);
        check("rst_yumi",   {63'd0, yumi_o}, 64'd0);
        check("rst_vaddr",  {25'd0, pf_vaddr_o}, 64'd0);
        check("rst_pc",     {25'd0, pf_pc_o}, 64'd0);

        // Case 1: 16 candidates (cap), two distinct lines.
        clear();
        send(39'h100, 39'h1000, 8'd8, 8'd20);
        collect(40);
        exp_q = '{39'h1040, 39'h1080};
        check_seq("c1_req");
        check("c1_end_idx", 64'(end_idx), 64'd17);

        // Case 2: one request per cycle, first two cycles after yumi.
        clear();
        send(39'h200, 39'h2000, 8'd64, 8'd4);
        collect(40);
        exp_q = '{39'h2040, 39'h2080, 39'h20C0, 39'h2100};
        check_seq("c2_req");
        if (got_idx.size() == 4) begin
            check("c2_first_lat", 64'(got_idx[0]), 64'd1);
            check("c2_last_idx",  64'(got_idx[3]), 64'd4);
        end
        check("c2_end_idx", 64'(end_idx), 64'd5);
        check("c2_pc", {25'd0, pf_pc_o}, 64'h200);

        // Case 3: negative stride walks downward.
        clear();
        send(39'h300, 39'h3000, 8'hC0, 8'd3);
        collect(40);
        exp_q = '{39'h2FC0, 39'h2F80, 39'h2F40};
        check_seq("c3_req");

        // Case 4: zero remaining iterations, then zero stride.
        clear();
        send(39'h400, 39'h4000, 8'd8, 8'd0);
        collect(10);
        check("c4a_reqs", 64'(got_q.size()), 64'd0);
        check("c4a_end_idx", 64'(end_idx), 64'd1);
        clear();
        send(39'h401, 39'h4000, 8'd0, 8'd5);
        collect(10);
        check("c4b_reqs", 64'(got_q.size()), 64'd0);
        check("c4b_end_idx", 64'(end_idx), 64'd1);

        // Case 5: backpressure holds the first request stable.
        clear();
        pf_ready_and_i = 1'b0;
        send(39'h500, 39'h2000, 8'd64, 8'd4);
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("c5_hold_v", {63'd0, pf_v_o}, 64'd1);
            check("c5_hold_addr", {25'd0, pf_vaddr_o}, 64'h2040);
        end
        pf_ready_and_i = 1'b1;
        #1 if (pf_v_o) got_q.push_back(pf_vaddr_o);
        collect(40);
        exp_q = '{39'h2040, 39'h2080, 39'h20C0, 39'h2100};
        check_seq("c5_req");

        // Case 6: flush on the second request, then a fresh descriptor.
        clear();
        send(39'h600, 39'h2000, 8'd64, 8'd4);
        @(negedge clk_i);
        @(negedge clk_i);
        check("c6_req1", {25'd0, pf_vaddr_o}, 64'h2040);
        @(negedge clk_i);
        check("c6_req2_v", {63'd0, pf_v_o}, 64'd1);
        check("c6_req2", {25'd0, pf_vaddr_o}, 64'h2080);
        flush_i = 1'b1; v_i = 1'b1;
        #1;
        check("c6_flush_pf_v", {63'd0, pf_v_o}, 64'd0);
        check("c6_flush_yumi", {63'd0, yumi_o}, 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; v_i = 1'b0;
        check("c6_idle", {63'd0, busy_o}, 64'd0);
        send(39'h601, 39'h3000, 8'hC0, 8'd3);
        collect(40);
        exp_q = '{39'h2FC0, 39'h2F80, 39'h2F40};
        check_seq("c6_new_req");
        check("c6_new_pc", {25'd0, pf_pc_o}, 64'h601);

        // Reset in the middle of ISSUE.
        send(39'h700, 39'h2000, 8'd64, 8'd4);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_mid_pf_v", {63'd0, pf_v_o}, 64'd1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        check("rst_mid_busy",  {63'd0, busy_o}, 64'd0);
        check("rst_mid_pf_v0", {63'd0, pf_v_o}, 64'd0);
        check("rst_mid_vaddr", {25'd0, pf_vaddr_o}, 64'd0);
        check("rst_mid_pc",    {25'd0, pf_pc_o}, 64'd0);

        // Address wrap at the top of the address space.
        clear();
        send(39'h800, 39'h7F_FFFF_FFC0, 8'd64, 8'd1);
        collect(10);
        exp_q = '{39'h0};
        check_seq("wrap_req");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
